muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only even values of 4 or more are legal.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port clear  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = signed multiply, 1 = signed divide.
REQ-006 SHALL have port a  input  WIDTH  signed multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  signed multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking valid hi/lo.
REQ-010 SHALL have port hi  output  WIDTH  product upper half or remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half or quotient.
REQ-012 SHALL have port div_by_zero  output  1  set with done when op=1 and b=0; held until next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE; DONE always returns to IDLE next cycle.
REQ-014 SHALL accept a request on a rising edge with start=1 in IDLE; a, b, op captured into internal registers at that edge; later input changes have no effect.
REQ-015 SHALL ignore start in every state other than IDLE (no queueing, no abort).
REQ-016 Multiply: SHALL clear accumulator and Booth carry bit E, then in MUL retire one radix-4 Booth digit per cycle, LSB first, for WIDTH/2 cycles.
REQ-017 Digit encoding on {b[2i+1], b[2i], E}: 000/111 -> +0, 001/010 -> +a, 011 -> +2a, 100 -> -2a, 101/110 -> -a; each term sign-extended to 2*WIDTH and shifted left 2i; E <- b[2i+1].
REQ-018 Multiply result SHALL equal the exact 2*WIDTH-bit signed product; {hi,lo} = product.
REQ-019 Divide: SHALL convert operands to magnitudes, run WIDTH restoring iterations in DIV (one quotient bit per cycle, MSB first), then apply signs in FIX.
REQ-020 Quotient SHALL truncate toward zero; remainder sign SHALL equal dividend sign; lo = quotient, hi = remainder.
REQ-021 Divide overflow (a = most negative, b = -1) SHALL wrap: lo = most negative value, hi = 0, no flag.
REQ-022 Divide by zero: SHALL skip DIV/FIX and go IDLE -> DONE; hi = a, lo = all ones, div_by_zero = 1.
REQ-023 hi, lo SHALL update only on entry to DONE and hold between operations.
REQ-024 Latency from accepting edge to done high: multiply WIDTH/2+1 cycles; divide WIDTH+2 cycles; divide-by-zero 1 cycle.
REQ-025 busy SHALL rise the cycle after acceptance and fall in the cycle done is high... -- precisely: busy = 1 in MUL, DIV, FIX, DONE; 0 in IDLE.
REQ-026 Iteration counter SHALL cover 0..WIDTH-1 with no wrap into a further iteration; the terminal count transitions state.

Reset
REQ-027 On clear low, SHALL immediately force IDLE; busy, done, div_by_zero = 0; hi, lo, accumulator, counter, E = 0.
REQ-028 Clear asserted mid-operation SHALL abandon the operation with no done pulse; first request after clear release starts cleanly.
REQ-029 A start coincident with the clear-release edge SHALL be ignored.

Verification
REQ-030 WIDTH=32, a=7, b=-3, op=0 -> done 17 cycles after accept, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-031 a=b=80000000, op=0 -> hi=40000000, lo=00000000; a=FFFFFFFF, b=FFFFFFFF -> hi=0, lo=1.
REQ-032 a=-7, b=2, op=1 -> done 34 cycles after accept, lo=FFFFFFFD, hi=FFFFFFFF; a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-033 a=5, b=0, op=1 -> done 1 cycle after accept, div_by_zero=1, hi=5, lo=FFFFFFFF; next multiply clears flag.
REQ-034 Start pulsed with new operands at cycle 5 of a multiply -> ignored; original result and timing unchanged; busy stays high.
REQ-035 Clear pulsed low at cycle 10 of a divide -> outputs 0 asynchronously, no done; fresh 6*7 multiply afterward -> hi=0, lo=2A.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle for the signed multiply/divide sequencer.
// The requester drives start/op/a/b; the sequencer returns status and hi/lo.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative signed multiplier (radix-4 Booth) and restoring divider sharing
// one accumulator.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// MUL   | one Booth digit per cycle, LSB first, WIDTH/2 cycles
// DIV   | one restoring quotient bit per cycle, MSB first, WIDTH cycles
// FIX   | apply quotient/remainder signs to the magnitudes
// DONE  | hi/lo valid, done pulses, back to IDLE next cycle
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic         clock,
  input logic         clear,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic               e;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               neg_r;
  logic               armed;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  // mc holds the sign-extended multiplicand already shifted to the current digit
  always_comb begin
    term = '0;
    case ({mp[1:0], e})
      3'b001, 3'b010: term = mc;
      3'b011:         term = mc << 1;
      3'b100:         term = -(mc << 1);
      3'b101, 3'b110: term = -mc;
      default:        term = '0;
    endcase
  end

  assign mul_sum = acc + term;
  assign mag_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign mag_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;

  // Divide: acc = {remainder, dividend/quotient}, mc[WIDTH-1:0] = divisor magnitude
  assign rem     = acc[2*WIDTH-1:WIDTH];
  assign quo     = acc[WIDTH-1:0];
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, mc[WIDTH-1:0]};
  assign div_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign div_q   = {quo[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      e      <= 1'b0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      armed  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      armed  <= 1'b1;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // armed keeps a start on the reset-release edge from being taken
          if (bus.start && armed) begin
            busy_r <= 1'b1;
            dbz_r  <= 1'b0;
            if (bus.op && (bus.b == '0)) begin
              state  <= DONE;
              hi_r   <= bus.a;
              lo_r   <= '1;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
            end else if (bus.op) begin
              state <= DIV;
              acc   <= {{WIDTH{1'b0}}, mag_a};
              mc    <= {{WIDTH{1'b0}}, mag_b};
              neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_r <= bus.a[WIDTH-1];
              cnt   <= CW'(WIDTH - 1);
            end else begin
              state <= MUL;
              acc   <= '0;
              e     <= 1'b0;
              mc    <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
              mp    <= bus.b;
              cnt   <= CW'(WIDTH / 2 - 1);
            end
          end
        end
        MUL: begin
          acc <= mul_sum;
          mc  <= mc << 2;
          mp  <= mp >> 2;
          e   <= mp[1];
          if (cnt == '0) begin
            state  <= DONE;
            hi_r   <= mul_sum[2*WIDTH-1:WIDTH];
            lo_r   <= mul_sum[WIDTH-1:0];
            done_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          acc <= {div_rem, div_q};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          // most-negative / -1 wraps naturally: negating 2^(WIDTH-1) yields itself
          state  <= DONE;
          hi_r   <= neg_r ? -rem : rem;
          lo_r   <= neg_q ? -quo : quo;
          done_r <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected results, a
// negedge monitor pops and compares whenever done is seen.
module tb_muldiv_ctrl;
  logic clock = 1'b0;
  logic clear = 1'b0;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check({x.name, ".hi"},  64'(bus.hi), 64'(x.hi));
        check({x.name, ".lo"},  64'(bus.lo), 64'(x.lo));
        check({x.name, ".dbz"}, 64'(bus.div_by_zero), 64'(x.dbz));
        check({x.name, ".lat"}, 64'(cyc - x.acc_cyc + 1), 64'(x.lat));
      end
    end
  end

  task automatic issue(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int lat);
    exp_t x;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock);
    #1;
    x.name = name; x.hi = ehi; x.lo = elo; x.dbz = edbz; x.lat = lat; x.acc_cyc = cyc;
    sb.push_back(x);
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0BAD_F00D;
    check({name, ".busy_rise"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({name, ".idle_timeout"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int lat);
    issue(name, op, a, b, ehi, elo, edbz, lat);
    wait_idle(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hi",   64'(bus.hi),   64'd0);
    check("rst.lo",   64'(bus.lo),   64'd0);
    check("rst.dbz",  64'(bus.div_by_zero), 64'd0);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    repeat (2) @(negedge clock);

    run("mul_7x-3",   1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 17);
    run("mul_min2",   1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 17);
    run("mul_m1m1",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 17);
    run("mul_shift",  1'b0, 32'h1234_5678,  32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 17);
    run("div_-7/2",   1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run("div_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
    run("div_100/7",  1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 34);
    run("div_7/-2",   1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34);
    run("div_5/0",    1'b1, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1);
    repeat (3) @(negedge clock);
    check("dbz_hold", 64'(bus.div_by_zero), 64'd1);
    check("hi_hold",  64'(bus.hi),          64'd5);
    run("mul_clrflag", 1'b0, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 17);

    // start during a multiply with new operands must be ignored
    issue("mul_ignore", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 17);
    repeat (4) @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd6;
    bus.b     = 32'd0;
    @(negedge clock);
    bus.start = 1'b0;
    check("mul_ignore.busy", 64'(bus.busy), 64'd1);
    wait_idle("mul_ignore");

    // clear in the middle of a divide
    issue("div_abort", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    repeat (9) @(negedge clock);
    clear = 1'b0;
    #1;
    sb.delete();
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.hi",   64'(bus.hi),   64'd0);
    check("abort.lo",   64'(bus.lo),   64'd0);
    check("abort.dbz",  64'(bus.div_by_zero), 64'd0);
    repeat (40) @(negedge clock);
    // start present when clear releases is ignored
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    clear     = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check("release_start.busy", 64'(bus.busy), 64'd0);
    run("mul_6x7", 1'b0, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 1'b0, 17);

    repeat (5) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
